// File: rtl/la_uart_pkg.sv
// la_uart_pkg: shared UART types, framing constants and parity helper
// Items: uart_state_e, UART_DATA_BITS, UART_IDLE_LEVEL, UART_START_LEVEL, parity_bit()
package la_uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter, 0..CLKS_PER_BIT-1, wrapping on each bit boundary
// Ports: clk, rst (sync, active-high), clear_i (hold count at 0),
//        bit_end_o (current cycle is the last of a bit), next_end_o (next cycle will be)
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic bit_end_o,
    output logic next_end_o
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign bit_end_o  = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign next_end_o = !clear_i && cnt_q == CW'(CLKS_PER_BIT - 2);
    always_comb cnt_d = (clear_i || bit_end_o) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit UART serialiser with valid/ready input, optional parity, 1-2 stop bits
// Ports: clk, rst (sync, active-high), tx_data/tx_valid/tx_ready (byte handshake),
//        tx (serial line, idles high), busy (frame in progress), done (last cycle of frame)
module uart_transmitter
    import la_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    uart_state_e state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic par_q, par_d, tx_q, tx_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic bit_end, next_end;
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == IDLE),
        .bit_end_o (bit_end),
        .next_end_o(next_end)
    );
    // The bit counter doubles as the stop-bit counter, so STOP ends when it reaches STOP_BITS-1.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            IDLE: if (tx_valid) begin
                state_d = START;
                shift_d = tx_data;
                par_d   = parity_bit(tx_data, PARITY_ODD != 0);
                bit_d   = '0;
            end
            START:  if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: if (bit_end) begin
                state_d = (bit_q == 3'(STOP_BITS - 1)) ? IDLE : STOP;
                bit_d   = (bit_q == 3'(STOP_BITS - 1)) ? 3'd0 : bit_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from next state so that every output comes straight from a flop.
        tx_d    = (state_d == START)  ? UART_START_LEVEL :
                  (state_d == DATA)   ? shift_d[0] :
                  (state_d == PARITY) ? par_d : UART_IDLE_LEVEL;
        busy_d  = state_d != IDLE;
        ready_d = state_d == IDLE;
        done_d  = state_d == STOP && bit_d == 3'(STOP_BITS - 1) && next_end;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= UART_IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized and directed frame checks of four uart_transmitter configurations
module tb_uart_transmitter;
    localparam int NC = 4;
    localparam int CPB[NC] = '{4, 4, 4, 2};
    localparam int PE[NC]  = '{0, 1, 1, 0};
    localparam int PO[NC]  = '{0, 0, 1, 0};
    localparam int SB[NC]  = '{1, 1, 2, 2};
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] data[NC];
    logic valid[NC];
    logic ready_w[NC], tx_w[NC], busy_w[NC], done_w[NC];
    int acc[NC] = '{0, 0, 0, 0};
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < NC; g++) begin : g_dut
        uart_transmitter #(
            .CLKS_PER_BIT(CPB[g]),
            .PARITY_EN   (PE[g]),
            .PARITY_ODD  (PO[g]),
            .STOP_BITS   (SB[g])
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .tx_data (data[g]),
            .tx_valid(valid[g]),
            .tx_ready(ready_w[g]),
            .tx      (tx_w[g]),
            .busy    (busy_w[g]),
            .done    (done_w[g])
        );
    end
    always @(posedge clk)
        for (int i = 0; i < NC; i++)
            if (!rst && valid[i] && ready_w[i]) acc[i] <= acc[i] + 1;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Frame bit i of byte d: start, LSB-first data, optional parity, then stop level.
    function automatic logic exp_bit(input int c, input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == 9 && PE[c] != 0) return (^d) ^ (PO[c] != 0);
        return 1'b1;
    endfunction
    task automatic check_idle(input int c, input string tag);
        check($sformatf("c%0d %s tx", c, tag), tx_w[c], 1);
        check($sformatf("c%0d %s ready", c, tag), ready_w[c], 1);
        check($sformatf("c%0d %s busy", c, tag), busy_w[c], 0);
        check($sformatf("c%0d %s done", c, tag), done_w[c], 0);
    endtask
    // Called #1 after the accept edge. mode: 0 plain, 1 keep valid with next byte nd,
    // 2 disturb tx_data/tx_valid mid-frame, 3 reset in the middle of data bit 3.
    task automatic watch(input int c, input logic [7:0] d, input int mode, input logic [7:0] nd);
        int n;
        n = CPB[c] * (9 + PE[c] + SB[c]);
        if (mode == 1) data[c] = nd;
        else valid[c] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (mode == 2 && k == 10) begin data[c] = 8'hFF; valid[c] = 1'b1; end
            if (mode == 2 && k == 11) valid[c] = 1'b0;
            if (mode == 3 && k == 4 * CPB[c] + CPB[c] / 2) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_idle(c, "abort");
                @(posedge clk); #1;
                check_idle(c, "abort+1");
                return;
            end
            check($sformatf("c%0d d%02h tx k%0d", c, d, k), tx_w[c], exp_bit(c, d, k / CPB[c]));
            check($sformatf("c%0d d%02h busy k%0d", c, d, k), busy_w[c], 1);
            check($sformatf("c%0d d%02h ready k%0d", c, d, k), ready_w[c], 0);
            check($sformatf("c%0d d%02h done k%0d", c, d, k), done_w[c], (k == n - 1) ? 1 : 0);
            @(posedge clk); #1;
        end
        check_idle(c, "post");
    endtask
    task automatic send(input int c, input logic [7:0] d, input int mode, input logic [7:0] nd);
        data[c]  = d;
        valid[c] = 1'b1;
        check($sformatf("c%0d ready pre", c), ready_w[c], 1);
        @(posedge clk); #1;
        watch(c, d, mode, nd);
    endtask
    initial begin
        int a0;
        for (int i = 0; i < NC; i++) begin valid[i] = 1'b0; data[i] = 8'h00; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NC; i++) check_idle(i, "reset");
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) check_idle(i, "hold");
        send(0, 8'hA5, 0, 8'h00);
        send(1, 8'h07, 0, 8'h00);
        send(2, 8'h07, 0, 8'h00);
        a0 = acc[0];
        send(0, 8'h55, 1, 8'hAA);
        @(posedge clk); #1;
        watch(0, 8'hAA, 0, 8'h00);
        check("c0 b2b accepts", acc[0] - a0, 2);
        a0 = acc[1];
        send(1, 8'h3A, 2, 8'h00);
        @(posedge clk); #1;
        check_idle(1, "disturb");
        check("c1 disturb accepts", acc[1] - a0, 1);
        data[1] = 8'h00;
        send(0, 8'hC3, 3, 8'h00);
        send(0, 8'h3C, 0, 8'h00);
        send(3, 8'h96, 3, 8'h00);
        send(3, 8'h3C, 0, 8'h00);
        for (int c = 0; c < NC; c++)
            repeat (4) begin
                send(c, 8'($urandom), 0, 8'h00);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- 8-bit UART serial transmitter: the transmit end of the analyzer's UART path, complementing the existing UART receive decoder.
- Accepts bytes over a valid/ready handshake and serialises them LSB-first on a single pin: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Use cases: streams FIFO contents or captured data off-chip; loopback stimulus source for the UART decoder.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal values are 2 or more.
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only at accept.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  transmitter can accept a byte.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst=1 at an edge): tx=1, tx_ready=1, busy=0, done=0, state=IDLE; bit counter and baud counter cleared. Reset wins over every other event.
- All outputs are registered; tx has no combinational path from inputs.
- Accept: a handshake occurs at an edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register.
  - State moves to START; tx_ready=0 and busy=1 from the next cycle.
- tx_ready is high only in IDLE. tx_valid while busy is ignored, and tx_data changes after accept have no effect.
- States and transitions:
  - IDLE: tx=1; goes to START on accept.
  - START: tx=0 for CLKS_PER_BIT cycles; goes to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right, 8 bits.
  - From DATA: to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: tx = XOR of the 8 data bits, XORed with PARITY_ODD, for CLKS_PER_BIT cycles; goes to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; goes to IDLE.
- Latency: tx falls the cycle after the accept edge.
- Frame length: N = CLKS_PER_BIT*(9+PARITY_EN+STOP_BITS) cycles of busy=1.
- done=1 exactly during the final cycle of the last stop bit. tx_ready=1 the following cycle.
- Back-to-back: with tx_valid held high, the next accept occurs in that single IDLE cycle. The gap between frames is exactly 1 clock of tx=1.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Bit counter: 3 bits; wraps after data bit 7 with the state change.
- Reset mid-frame: frame aborted; tx=1 and tx_ready=1 the next cycle; no done pulse.

Decomposition:
- Shared package la_uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - constant UART_DATA_BITS=8;
  - constants UART_IDLE_LEVEL=1 and UART_START_LEVEL=0, reused by the decoder.
- One natural sub-module: uart_bit_timer.
  - Baud counter with clear input and bit_end pulse output.
  - Parameterised by CLKS_PER_BIT.
  - Shareable with a future decoder rewrite.

Test Plan:
- Reset hold 3 cycles, then release -> tx=1, tx_ready=1, busy=0, done=0; stays idle with tx_valid=0.
- CLKS_PER_BIT=4, no parity, 1 stop; send 0xA5 -> tx shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles.
  - Starts 1 cycle after accept.
  - done high in cycle 40 of the frame; tx_ready high at cycle 41.
- PARITY_EN=1:
  - 0x07 with PARITY_ODD=0 -> parity bit 1.
  - 0x07 with PARITY_ODD=1 -> parity bit 0.
  - STOP_BITS=2 -> 8 stop cycles; frame 48 cycles.
- tx_valid held high with 0x55 then 0xAA -> two frames separated by exactly 1 idle-high clock; exactly two accepts; second frame bits match 0xAA.
- During a frame, toggle tx_data to 0xFF and pulse tx_valid -> transmitted bits unchanged, no extra accept, tx_ready stays 0.
- Assert rst in the middle of data bit 3 -> tx=1, busy=0, tx_ready=1 next cycle, no done pulse; then 0x3C sends correctly.
